// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param
// True dual-port synchronous RAM with per-byte write enables and a
// selectable same-port read-during-write mode. An optional output register
// makes the read latency 2 instead of 1. Same-address byte collisions
// resolve in favour of port A. An optional zero-fill sweep runs after reset.
//
// Port handshake: an access is taken on a rising edge when en=1 and busy=0.
// The read result and its valid strobe appear together on out/valid
// 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1). There is no
// back-pressure; each port accepts one access per cycle.
//
// INIT_FILE names a binary preload image for the memory-initialisation
// flow of the implementation tools. The RTL itself does not read it.
module dual_port_ram_param #(
    parameter int    DATA_WIDTH     = 16,
    parameter int    ADDR_WIDTH     = 15,
    parameter int    READ_MODE      = 0,
    parameter int    OUT_REG        = 0,
    parameter int    CLEAR_ON_RESET = 0,
    parameter string INIT_FILE      = ""
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      port_a_en,
    input  logic [DATA_WIDTH/8-1:0]   port_a_we,
    input  logic [ADDR_WIDTH-1:0]     port_a_address,
    input  logic [DATA_WIDTH-1:0]     port_a_in,
    output logic [DATA_WIDTH-1:0]     port_a_out,
    output logic                      port_a_valid,
    input  logic                      port_b_en,
    input  logic [DATA_WIDTH/8-1:0]   port_b_we,
    input  logic [ADDR_WIDTH-1:0]     port_b_address,
    input  logic [DATA_WIDTH-1:0]     port_b_in,
    output logic [DATA_WIDTH-1:0]     port_b_out,
    output logic                      port_b_valid,
    output logic                      busy,
    output logic                      collision,
    output logic                      dbg_clear_state
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } clr_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_t          state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                sweep_we;

    // Per-port views, index 0 = port A, 1 = port B.
    logic                  acc      [2];
    logic                  wr       [2];
    logic [NB-1:0]         we       [2];
    logic [ADDR_WIDTH-1:0] addr     [2];
    logic [DATA_WIDTH-1:0] wdata    [2];
    logic [DATA_WIDTH-1:0] old_word [2];
    logic [DATA_WIDTH-1:0] rd_word  [2];
    logic                  rd_load  [2];
    logic                  rd_hold  [2];

    // Inputs of the final output register (direct or via the extra stage).
    logic                  src_load [2];
    logic                  src_hold [2];
    logic [DATA_WIDTH-1:0] src_data [2];

    logic [DATA_WIDTH-1:0] out_q    [2];
    logic                  valid_q  [2];
    logic                  same_addr;
    logic                  coll_d;

    assign busy            = (state_q == ST_SWEEP);
    assign dbg_clear_state = state_q;
    assign sweep_we        = busy && reset_n;

    assign we[0]    = port_a_we;
    assign we[1]    = port_b_we;
    assign addr[0]  = port_a_address;
    assign addr[1]  = port_b_address;
    assign wdata[0] = port_a_in;
    assign wdata[1] = port_b_in;

    assign port_a_out   = out_q[0];
    assign port_a_valid = valid_q[0];
    assign port_b_out   = out_q[1];
    assign port_b_valid = valid_q[1];

    // Clear-sweep state and address counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_SWEEP : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep advances one word per cycle and stops once the counter's top bit
    // shows that word DEPTH-1 has been written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_SWEEP) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d[ADDR_WIDTH]) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Access decode and same-port read word (old or merged new word).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            acc[p]      = (p == 0 ? port_a_en : port_b_en) && !busy;
            wr[p]       = acc[p] && (we[p] != '0);
            old_word[p] = mem[addr[p]];
            rd_word[p]  = old_word[p];
            if (READ_MODE == 0) begin
                for (int i = 0; i < NB; i++) begin
                    if (we[p][i]) begin
                        rd_word[p][i*8 +: 8] = wdata[p][i*8 +: 8];
                    end
                end
            end
            rd_load[p] = acc[p] && !((READ_MODE == 2) && wr[p]);
            rd_hold[p] = acc[p] &&  ((READ_MODE == 2) && wr[p]);
        end
        same_addr = (addr[0] == addr[1]);
        coll_d    = wr[0] && wr[1] && same_addr && ((we[0] & we[1]) != '0);
    end

    // Memory writes: sweep zero-fill, else port B then port A so A wins overlaps.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt_q[ADDR_WIDTH-1:0]] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr[1] && we[1][i]) begin
                    mem[addr[1]][i*8 +: 8] <= wdata[1][i*8 +: 8];
                end
                if (wr[0] && we[0][i]) begin
                    mem[addr[0]][i*8 +: 8] <= wdata[0][i*8 +: 8];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  s_load [2];
            logic                  s_hold [2];
            logic [DATA_WIDTH-1:0] s_data [2];

            // Extra pipeline stage carrying read data and its load/hold intent.
            always_ff @(posedge clk) begin
                for (int p = 0; p < 2; p++) begin
                    if (!reset_n) begin
                        s_load[p] <= 1'b0;
                        s_hold[p] <= 1'b0;
                        s_data[p] <= '0;
                    end else begin
                        s_load[p] <= rd_load[p];
                        s_hold[p] <= rd_hold[p];
                        s_data[p] <= rd_word[p];
                    end
                end
            end

            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    src_load[p] = s_load[p];
                    src_hold[p] = s_hold[p];
                    src_data[p] = s_data[p];
                end
            end
        end else begin : g_no_out_reg
            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    src_load[p] = rd_load[p];
                    src_hold[p] = rd_hold[p];
                    src_data[p] = rd_word[p];
                end
            end
        end
    endgenerate

    // Output register: load on a read result, hold on a no-change write, else drop valid.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (!reset_n) begin
                out_q[p]   <= '0;
                valid_q[p] <= 1'b0;
            end else if (src_load[p]) begin
                out_q[p]   <= src_data[p];
                valid_q[p] <= 1'b1;
            end else if (!src_hold[p]) begin
                valid_q[p] <= 1'b0;
            end
        end
    end

    // Collision pulse, registered one cycle after the colliding edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            collision <= 1'b0;
        end else begin
            collision <= coll_d;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench for dual_port_ram_param: write-first/read-first/no-change,
// output register latency, byte enables, collisions and the clear sweep.
module tb_dual_port_ram_param;

    logic        clk;
    logic        reset_n;
    logic        a_en, b_en;
    logic [1:0]  a_we, b_we;
    logic [14:0] a_addr, b_addr;
    logic [15:0] a_in, b_in;

    logic [4:0][15:0] oa, ob;
    logic [4:0]       va, vb, bz, co, ds;

    int checks   = 0;
    int failures = 0;
    int n;

    // 0: write-first, 1: read-first, 2: no-change, 3: write-first + OUT_REG,
    // 4: 16-word with clear sweep
    dual_port_ram_param #(.ADDR_WIDTH(15), .READ_MODE(0)) u0 (
        .clk(clk), .reset_n(reset_n),
        .port_a_en(a_en), .port_a_we(a_we), .port_a_address(a_addr), .port_a_in(a_in),
        .port_a_out(oa[0]), .port_a_valid(va[0]),
        .port_b_en(b_en), .port_b_we(b_we), .port_b_address(b_addr), .port_b_in(b_in),
        .port_b_out(ob[0]), .port_b_valid(vb[0]),
        .busy(bz[0]), .collision(co[0]), .dbg_clear_state(ds[0]));

    dual_port_ram_param #(.ADDR_WIDTH(8), .READ_MODE(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .port_a_en(a_en), .port_a_we(a_we), .port_a_address(a_addr[7:0]), .port_a_in(a_in),
        .port_a_out(oa[1]), .port_a_valid(va[1]),
        .port_b_en(b_en), .port_b_we(b_we), .port_b_address(b_addr[7:0]), .port_b_in(b_in),
        .port_b_out(ob[1]), .port_b_valid(vb[1]),
        .busy(bz[1]), .collision(co[1]), .dbg_clear_state(ds[1]));

    dual_port_ram_param #(.ADDR_WIDTH(8), .READ_MODE(2)) u2 (
        .clk(clk), .reset_n(reset_n),
        .port_a_en(a_en), .port_a_we(a_we), .port_a_address(a_addr[7:0]), .port_a_in(a_in),
        .port_a_out(oa[2]), .port_a_valid(va[2]),
        .port_b_en(b_en), .port_b_we(b_we), .port_b_address(b_addr[7:0]), .port_b_in(b_in),
        .port_b_out(ob[2]), .port_b_valid(vb[2]),
        .busy(bz[2]), .collision(co[2]), .dbg_clear_state(ds[2]));

    dual_port_ram_param #(.ADDR_WIDTH(8), .READ_MODE(0), .OUT_REG(1)) u3 (
        .clk(clk), .reset_n(reset_n),
        .port_a_en(a_en), .port_a_we(a_we), .port_a_address(a_addr[7:0]), .port_a_in(a_in),
        .port_a_out(oa[3]), .port_a_valid(va[3]),
        .port_b_en(b_en), .port_b_we(b_we), .port_b_address(b_addr[7:0]), .port_b_in(b_in),
        .port_b_out(ob[3]), .port_b_valid(vb[3]),
        .busy(bz[3]), .collision(co[3]), .dbg_clear_state(ds[3]));

    dual_port_ram_param #(.ADDR_WIDTH(4), .CLEAR_ON_RESET(1)) u4 (
        .clk(clk), .reset_n(reset_n),
        .port_a_en(a_en), .port_a_we(a_we), .port_a_address(a_addr[3:0]), .port_a_in(a_in),
        .port_a_out(oa[4]), .port_a_valid(va[4]),
        .port_b_en(b_en), .port_b_we(b_we), .port_b_address(b_addr[3:0]), .port_b_in(b_in),
        .port_b_out(ob[4]), .port_b_valid(vb[4]),
        .busy(bz[4]), .collision(co[4]), .dbg_clear_state(ds[4]));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_ports();
        a_en = 0; a_we = 2'b00; a_addr = '0; a_in = '0;
        b_en = 0; b_we = 2'b00; b_addr = '0; b_in = '0;
    endtask

    initial begin
        reset_n = 0;
        idle_ports();
        step();
        step();
        check("rst_out_a",     oa[0], 16'h0000);
        check("rst_valid_a",   va[0], 1'b0);
        check("rst_collision", co[0], 1'b0);
        check("rst_outreg",    oa[3], 16'h0000);
        check("rst_busy",      bz[4], 1'b1);

        // Sweep after release; port A keeps trying to write 0xFFFF to word 0.
        reset_n = 1;
        a_en = 1; a_we = 2'b11; a_addr = 15'h0000; a_in = 16'hFFFF;
        n = 0;
        while (bz[4] && n < 100) begin
            step();
            n++;
            check("busy_no_valid", va[4], 1'b0);
        end
        idle_ports();
        check("busy_len", n, 16);

        // Every word reads back zero, including the one written while busy.
        for (int i = 0; i < 16; i++) begin
            a_en = 1; a_we = 2'b00; a_addr = 15'(i);
            step();
            check("sweep_zero", oa[4], 16'h0000);
            check("sweep_valid", va[4], 1'b1);
        end
        idle_ports();

        // Reset pulsed partway through a sweep restarts it.
        reset_n = 0;
        step();
        reset_n = 1;
        repeat (7) step();
        check("mid_sweep_busy", bz[4], 1'b1);
        reset_n = 0;
        step();
        check("restart_busy_in_reset", bz[4], 1'b1);
        reset_n = 1;
        n = 0;
        while (bz[4] && n < 100) begin
            step();
            n++;
        end
        check("restart_busy_len", n, 16);

        // Write-first: write 0xBEEF at 0x0010, then read it back.
        a_en = 1; a_we = 2'b11; a_addr = 15'h0010; a_in = 16'hBEEF;
        step();
        check("wf_out", oa[0], 16'hBEEF);
        check("wf_valid", va[0], 1'b1);
        a_we = 2'b00;
        step();
        check("wf_readback", oa[0], 16'hBEEF);

        // Byte enables: 0x1234 then low byte of 0xABCD -> 0x12CD.
        a_we = 2'b11; a_addr = 15'h0020; a_in = 16'h1234;
        step();
        a_we = 2'b01; a_in = 16'hABCD;
        step();
        check("be_merged_a", oa[0], 16'h12CD);
        a_en = 0;
        b_en = 1; b_we = 2'b00; b_addr = 15'h0020;
        step();
        check("be_read_b", ob[0], 16'h12CD);
        check("be_valid_b", vb[0], 1'b1);
        idle_ports();

        // Read modes at 0x0030: 0x1111, read it, idle, then write 0x2222.
        a_en = 1; a_we = 2'b11; a_addr = 15'h0030; a_in = 16'h1111;
        step();
        a_we = 2'b00;
        step();
        check("rm_read_nc", oa[2], 16'h1111);
        a_en = 0;
        step();
        check("rm_idle_valid", va[0], 1'b0);
        a_en = 1; a_we = 2'b11; a_in = 16'h2222;
        step();
        check("rm0_out", oa[0], 16'h2222);
        check("rm1_out", oa[1], 16'h1111);
        check("rm1_valid", va[1], 1'b1);
        check("rm2_out_hold", oa[2], 16'h1111);
        check("rm2_valid", va[2], 1'b0);
        check("oreg_not_yet", va[3], 1'b0);
        check("oreg_old_out", oa[3], 16'h1111);
        a_en = 0; a_we = 2'b00;
        step();
        check("oreg_out", oa[3], 16'h2222);
        check("oreg_valid", va[3], 1'b1);
        check("rm2_valid_later", va[2], 1'b0);

        // Full-overlap collision at 0x0040: A wins, pulse one cycle.
        a_en = 1; a_we = 2'b11; a_addr = 15'h0040; a_in = 16'hAAAA;
        b_en = 1; b_we = 2'b11; b_addr = 15'h0040; b_in = 16'h5555;
        step();
        check("coll_pulse", co[0], 1'b1);
        a_en = 0; b_we = 2'b00;
        step();
        check("coll_drop", co[0], 1'b0);
        check("coll_mem", ob[0], 16'hAAAA);
        idle_ports();

        // Cross-port read during a write sees the old word.
        a_en = 1; a_we = 2'b11; a_addr = 15'h0050; a_in = 16'h7777;
        step();
        a_in = 16'h8888;
        b_en = 1; b_we = 2'b00; b_addr = 15'h0050;
        step();
        check("xport_old", ob[0], 16'h7777);
        check("xport_writer", oa[0], 16'h8888);
        check("xport_no_coll", co[0], 1'b0);
        idle_ports();

        // Disjoint-byte writes to 0x0040: both land, no collision.
        a_en = 1; a_we = 2'b10; a_addr = 15'h0040; a_in = 16'hAAAA;
        b_en = 1; b_we = 2'b01; b_addr = 15'h0040; b_in = 16'h5555;
        step();
        check("disjoint_no_coll", co[0], 1'b0);
        a_en = 0; b_we = 2'b00;
        step();
        check("disjoint_mem", ob[0], 16'hAA55);
        check("disjoint_no_coll2", co[0], 1'b0);
        idle_ports();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
